fib_sram_ctrl: RTL and testbench

FIB_SRAM_CTRL -- requirements
Module: fib_sram_ctrl

---
 rtl/fib_pkg.sv | 24 ++
 rtl/fib_sram_ctrl_if.sv | 42 ++++
 rtl/fib_term_gen.sv | 60 ++++++
 rtl/fib_sram_ctrl.sv | 146 ++++++++++++++
 tb/tb_fib_sram_ctrl.sv | 373 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fib_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fib_pkg                                                                |
// | Shared controller state encoding and default parameter constants.     |
// | Ports: none (package).                                                 |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package fib_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_READ_LAT   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_RD_ISSUE = 3'd2,
    ST_RD_WAIT  = 3'd3,
    ST_OUT      = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fib_sram_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fib_sram_ctrl_if                                                       |
// | Control, streaming and SRAM-wrapper bus of the Fibonacci controller.  |
// | Ports (master = controller side):                                      |
// |   in : start, out_ready, sram_rdata                                    |
// |   out: busy, done, overflow, out_data, out_valid,                      |
// |        sram_we, sram_oe, sram_addr, sram_wdata                         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
interface fib_sram_ctrl_if #(
  parameter int ADDR_WIDTH = fib_pkg::DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = fib_pkg::DEF_DATA_WIDTH
);

  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  sram_we;
  logic                  sram_oe;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_wdata;
  logic [DATA_WIDTH-1:0] sram_rdata;

  modport master (
    input  start, out_ready, sram_rdata,
    output busy, done, overflow, out_data, out_valid,
           sram_we, sram_oe, sram_addr, sram_wdata
  );

  modport slave (
    output start, out_ready, sram_rdata,
    input  busy, done, overflow, out_data, out_valid,
           sram_we, sram_oe, sram_addr, sram_wdata
  );

endinterface
`default_nettype wire

// File: rtl/fib_term_gen.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fib_term_gen                                                           |
// | Fibonacci term generator: registers a (current term) and b (next      |
// | term), adder a+b, and a truncation flag travelling with each term.    |
// | Ports:                                                                 |
// |   clk, rst   : clock, synchronous active-high reset                    |
// |   init_i     : load F(0)/F(1)                                          |
// |   step_i     : advance one term                                        |
// |   term_o     : current term a                                          |
// |   carry_o    : current term was produced by an overflowing addition    |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module fib_term_gen
  import fib_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_i,
  input  logic                  step_i,
  output logic [DATA_WIDTH-1:0] term_o,
  output logic                  carry_o
);

  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  ca_q;   // a_q is a truncated term
  logic                  cb_q;   // b_q is a truncated term
  logic [DATA_WIDTH:0]   sum;

  assign sum = {1'b0, a_q} + {1'b0, b_q};

  // The carry is delayed with its term so it surfaces exactly when that
  // term is presented on term_o (i.e. when it gets stored).
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      ca_q <= 1'b0;
      cb_q <= 1'b0;
    end else if (init_i) begin
      a_q  <= '0;
      b_q  <= {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      ca_q <= 1'b0;
      cb_q <= 1'b0;
    end else if (step_i) begin
      a_q  <= b_q;
      b_q  <= sum[DATA_WIDTH-1:0];
      ca_q <= cb_q;
      cb_q <= sum[DATA_WIDTH];
    end
  end

  assign term_o  = a_q;
  assign carry_o = ca_q;

endmodule
`default_nettype wire

// File: rtl/fib_sram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | fib_sram_ctrl                                                          |
// | Fills an external SRAM with the first 2^ADDR_WIDTH Fibonacci terms,   |
// | then reads them back one at a time and streams them with valid/ready. |
// | Ports:                                                                 |
// |   clk, rst : clock, synchronous active-high reset                      |
// |   bus      : fib_sram_ctrl_if.master (start/busy/done/overflow,        |
// |              out_* stream, sram_* wrapper bus)                         |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module fib_sram_ctrl
  import fib_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int READ_LAT   = DEF_READ_LAT
) (
  input  logic            clk,
  input  logic            rst,
  fib_sram_ctrl_if.master bus
);

  localparam int                    LAT_W    = $clog2(READ_LAT + 1);
  localparam logic [ADDR_WIDTH-1:0] K_LAST   = {ADDR_WIDTH{1'b1}};
  localparam logic [LAT_W-1:0]      LAT_LAST = LAT_W'(READ_LAT);

  state_t                state_q,    state_d;
  logic [ADDR_WIDTH-1:0] k_q,        k_d;
  logic [LAT_W-1:0]      cnt_q,      cnt_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  ovf_q,      ovf_d;

  logic                  gen_init;
  logic                  gen_step;
  logic [DATA_WIDTH-1:0] term;
  logic                  carry;

  fib_term_gen #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_term_gen (
    .clk     (clk),
    .rst     (rst),
    .init_i  (gen_init),
    .step_i  (gen_step),
    .term_o  (term),
    .carry_o (carry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    gen_init   = 1'b0;
    gen_step   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        k_d = '0;
        if (bus.start) begin
          state_d  = ST_FILL;
          ovf_d    = 1'b0;
          gen_init = 1'b1;
        end
      end

      ST_FILL: begin
        gen_step = 1'b1;
        if (carry) begin
          ovf_d = 1'b1;
        end
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = ST_RD_ISSUE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      // cnt counts cycles elapsed since the address was issued.
      ST_RD_ISSUE: begin
        cnt_d   = LAT_W'(1);
        state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          out_data_d = bus.sram_rdata;
          state_d    = ST_OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_OUT: begin
        if (bus.out_ready) begin
          if (k_q == K_LAST) begin
            state_d = ST_DONE;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_RD_ISSUE;
          end
        end
      end

      ST_DONE: begin
        k_d     = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.overflow   = ovf_q;
  assign bus.out_valid  = (state_q == ST_OUT);
  assign bus.out_data   = out_data_q;
  assign bus.sram_we    = (state_q == ST_FILL);
  assign bus.sram_oe    = (state_q == ST_RD_ISSUE) || (state_q == ST_RD_WAIT);
  assign bus.sram_addr  = k_q;
  assign bus.sram_wdata = (state_q == ST_FILL) ? term : '0;

endmodule
`default_nettype wire

// File: tb/tb_fib_sram_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_fib_sram_ctrl                                                       |
// | Self-checking bench for fib_sram_ctrl with an SRAM wrapper model and  |
// | an arithmetic Fibonacci reference model.                              |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_fib_sram_ctrl;

  localparam int AW     = 4;
  localparam int DW     = 8;
  localparam int RL     = 2;
  localparam int DEPTH  = 1 << AW;
  localparam int BUDGET = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  fib_sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  assign bus.start     = start;
  assign bus.out_ready = out_ready;

  fib_sram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .READ_LAT   (RL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // SRAM wrapper model: data for the address presented with oe appears
  // RL cycles later; junk otherwise.
  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] rd_pipe [RL];

  always @(posedge clk) begin
    if (bus.sram_we) mem[bus.sram_addr] <= bus.sram_wdata;
    rd_pipe[0] <= bus.sram_oe ? mem[bus.sram_addr] : 8'hA5;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  assign bus.sram_rdata = rd_pipe[RL-1];

  // Bus monitor, active over every run.
  int            bus_viol  = 0;
  int            addr_viol = 0;
  logic          prev_oe   = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sram_we && bus.sram_oe) bus_viol <= bus_viol + 1;
      if (bus.sram_oe && prev_oe && (bus.sram_addr !== prev_addr)) addr_viol <= addr_viol + 1;
    end
    prev_oe   <= bus.sram_oe;
    prev_addr <= bus.sram_addr;
  end

  // Reference model: plain Fibonacci arithmetic, reduced mod 2^DW.
  int exp_word [DEPTH];
  int exp_trunc_first;

  task automatic build_model();
    longint fib [DEPTH];
    exp_trunc_first = -1;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 0)      fib[k] = 0;
      else if (k == 1) fib[k] = 1;
      else             fib[k] = fib[k-1] + fib[k-2];
      exp_word[k] = int'(fib[k] % (64'd1 << DW));
      if (fib[k] >= (64'd1 << DW) && exp_trunc_first < 0) exp_trunc_first = k;
    end
  endtask

  int checks = 0;
  int errors = 0;

  // Observations of one run.
  int wr_addr_q[$];
  int wr_data_q[$];
  int rd_q[$];
  int first_valid_cyc, done_cyc, done_pulses, ovf_first, stall_seen;
  int stall_changed, stall_oe;
  logic ovf_c1, ovf_at_done, idle_after_done;
  bit timed_out;

  // Pulses start at cycle 0 and records what the DUT does until one cycle
  // after done. Makes no comparisons itself.
  task automatic run_collect(input int stall_word, input int stall_len,
                             input bit rand_ready, input bit poke_start);
    int acc;
    int stall_cnt;
    logic [DW-1:0] held;
    bit fin;
    wr_addr_q.delete(); wr_data_q.delete(); rd_q.delete();
    first_valid_cyc = -1; done_cyc = -1; done_pulses = 0; ovf_first = -1;
    stall_changed = 0; stall_oe = 0; ovf_c1 = 1'b1; ovf_at_done = 1'b0;
    idle_after_done = 1'b0; timed_out = 1'b0;
    acc = 0; stall_cnt = 0; held = '0; fin = 1'b0;
    @(negedge clk);
    start = 1'b1;
    out_ready = 1'b0;
    for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke_start && bus.busy) start = 1'($urandom_range(0, 1));
      if (cyc == 1) ovf_c1 = bus.overflow;
      if (bus.overflow && ovf_first < 0) ovf_first = cyc;
      if (bus.sram_we) begin
        wr_addr_q.push_back(int'(bus.sram_addr));
        wr_data_q.push_back(int'(bus.sram_wdata));
      end
      if (bus.done) begin
        done_pulses++;
        done_cyc    = cyc;
        ovf_at_done = bus.overflow;
      end
      if (bus.out_valid) begin
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
        if (acc == stall_word && stall_cnt < stall_len) begin
          if (stall_cnt == 0) held = bus.out_data;
          else if (bus.out_data !== held) stall_changed++;
          if (bus.sram_oe) stall_oe++;
          stall_cnt++;
          out_ready = 1'b0;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          rd_q.push_back(int'(bus.out_data));
          acc++;
        end
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (done_cyc > 0 && cyc == done_cyc + 1) begin
        idle_after_done = !bus.busy;
        fin = 1'b1;
      end
    end
    start = 1'b0;
    out_ready = 1'b0;
    stall_seen = stall_cnt;
    if (!fin) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    logic [6+2*DW+AW-1:0] outs;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    outs = {bus.busy, bus.done, bus.overflow, bus.out_valid, bus.sram_we,
            bus.sram_oe, bus.out_data, bus.sram_addr, bus.sram_wdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_basic_stream();
    int bad;
    run_collect(-1, 0, 1'b0, 1'b0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL basic_timeout: got no done expected done within %0d cycles", BUDGET);
    end
    checks++;
    if (wr_addr_q.size() != DEPTH) begin
      errors++;
      $display("FAIL basic_write_count: got %0d expected %0d", wr_addr_q.size(), DEPTH);
    end
    bad = 0;
    for (int k = 0; k < wr_addr_q.size() && k < DEPTH; k++)
      if (wr_addr_q[k] != k || wr_data_q[k] != exp_word[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_write_data: got %0d bad writes expected 0", bad);
    end
    bad = 0;
    for (int k = 0; k < DEPTH; k++) if (int'(mem[k]) != exp_word[k]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_sram_contents: got %0d bad words expected 0", bad);
    end
    bad = 0;
    for (int k = 0; k < rd_q.size() && k < DEPTH; k++) if (rd_q[k] != exp_word[k]) bad++;
    checks++;
    if (rd_q.size() != DEPTH || bad != 0) begin
      errors++;
      $display("FAIL basic_stream: got %0d words %0d bad expected %0d words 0 bad", rd_q.size(), bad, DEPTH);
    end
    checks++;
    if (first_valid_cyc != DEPTH + RL + 2) begin
      errors++;
      $display("FAIL basic_first_valid_cycle: got %0d expected %0d", first_valid_cyc, DEPTH + RL + 2);
    end
    // Each further word costs issue + RL wait cycles + one OUT cycle.
    checks++;
    if (done_cyc != DEPTH + RL + 2 + (DEPTH - 1) * (RL + 2) + 1 || done_pulses != 1) begin
      errors++;
      $display("FAIL basic_done: got cycle %0d pulses %0d expected cycle %0d pulses 1",
               done_cyc, done_pulses, DEPTH + RL + 2 + (DEPTH - 1) * (RL + 2) + 1);
    end
    checks++;
    if (ovf_at_done !== 1'b1 || ovf_first != exp_trunc_first + 2) begin
      errors++;
      $display("FAIL basic_overflow: got %b first at cycle %0d expected 1 first at cycle %0d",
               ovf_at_done, ovf_first, exp_trunc_first + 2);
    end
    checks++;
    if (idle_after_done !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle_after_done: got busy expected idle");
    end
  endtask

  task automatic test_stall();
    int bad;
    run_collect(5, 10, 1'b0, 1'b0);
    bad = 0;
    for (int k = 0; k < rd_q.size() && k < DEPTH; k++) if (rd_q[k] != exp_word[k]) bad++;
    checks++;
    if (timed_out || rd_q.size() != DEPTH || bad != 0) begin
      errors++;
      $display("FAIL stall_stream: got %0d words %0d bad timeout %0d expected %0d words 0 bad",
               rd_q.size(), bad, timed_out, DEPTH);
    end
    checks++;
    if (stall_seen != 10 || stall_changed != 0 || stall_oe != 0) begin
      errors++;
      $display("FAIL stall_hold: got len %0d changes %0d oe %0d expected len 10 changes 0 oe 0",
               stall_seen, stall_changed, stall_oe);
    end
  endtask

  task automatic test_start_ignored();
    int bad;
    run_collect(-1, 0, 1'b1, 1'b1);
    bad = 0;
    for (int k = 0; k < wr_addr_q.size() && k < DEPTH; k++)
      if (wr_addr_q[k] != k || wr_data_q[k] != exp_word[k]) bad++;
    checks++;
    if (wr_addr_q.size() != DEPTH || bad != 0) begin
      errors++;
      $display("FAIL poke_writes: got %0d writes %0d bad expected %0d writes 0 bad", wr_addr_q.size(), bad, DEPTH);
    end
    bad = 0;
    for (int k = 0; k < rd_q.size() && k < DEPTH; k++) if (rd_q[k] != exp_word[k]) bad++;
    checks++;
    if (timed_out || rd_q.size() != DEPTH || bad != 0 || done_pulses != 1) begin
      errors++;
      $display("FAIL poke_stream: got %0d words %0d bad %0d done expected %0d words 0 bad 1 done",
               rd_q.size(), bad, done_pulses, DEPTH);
    end
    checks++;
    if (first_valid_cyc != DEPTH + RL + 2) begin
      errors++;
      $display("FAIL poke_first_valid_cycle: got %0d expected %0d", first_valid_cyc, DEPTH + RL + 2);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.overflow !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_overflow_hold: got ovf %b busy %b expected ovf 1 busy 0", bus.overflow, bus.busy);
    end
    run_collect(-1, 0, 1'b0, 1'b0);
    checks++;
    if (ovf_c1 !== 1'b0 || ovf_at_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_overflow_clear: got c1 %b done %b expected c1 0 done 1", ovf_c1, ovf_at_done);
    end
    bad = 0;
    for (int k = 0; k < rd_q.size() && k < DEPTH; k++) if (rd_q[k] != exp_word[k]) bad++;
    checks++;
    if (timed_out || rd_q.size() != DEPTH || bad != 0) begin
      errors++;
      $display("FAIL b2b_stream: got %0d words %0d bad expected %0d words 0 bad", rd_q.size(), bad, DEPTH);
    end
  endtask

  task automatic test_reset_mid_fill();
    logic [6+2*DW+AW-1:0] outs;
    int bad;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (bus.sram_we !== 1'b1 || int'(bus.sram_addr) != 7 || int'(bus.sram_wdata) != exp_word[7]) begin
      errors++;
      $display("FAIL midfill_k7: got we %b addr %0d data %0d expected we 1 addr 7 data %0d",
               bus.sram_we, bus.sram_addr, bus.sram_wdata, exp_word[7]);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {bus.busy, bus.done, bus.overflow, bus.out_valid, bus.sram_we,
            bus.sram_oe, bus.out_data, bus.sram_addr, bus.sram_wdata};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL midfill_reset_outputs: got %h expected 0", outs);
    end
    rst = 1'b0;
    run_collect(-1, 0, 1'b0, 1'b0);
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[0] != 0 || wr_data_q[0] != 0) begin
      errors++;
      $display("FAIL midfill_restart: got %0d writes first addr %0d expected first addr 0 data 0",
               wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[0] : -1);
    end
    bad = 0;
    for (int k = 0; k < rd_q.size() && k < DEPTH; k++) if (rd_q[k] != exp_word[k]) bad++;
    checks++;
    if (timed_out || rd_q.size() != DEPTH || bad != 0) begin
      errors++;
      $display("FAIL midfill_stream: got %0d words %0d bad expected %0d words 0 bad", rd_q.size(), bad, DEPTH);
    end
  endtask

  task automatic test_bus_checker();
    @(negedge clk);
    checks++;
    if (bus_viol != 0) begin
      errors++;
      $display("FAIL bus_we_oe_overlap: got %0d cycles expected 0", bus_viol);
    end
    checks++;
    if (addr_viol != 0) begin
      errors++;
      $display("FAIL bus_read_addr_stable: got %0d changes expected 0", addr_viol);
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_basic_stream();
    test_stall();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_fill();
    test_bus_checker();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
